// File: rtl/motor_cmd_deframer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | motor_cmd_deframer : UART bytes -> 5-byte frames -> per-channel regs     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module motor_cmd_deframer #(
  parameter int NUM_CH      = 10,
  parameter int TIMEOUT_CYC = 24000
) (
  input  logic                 CLK_SE_AR,
  input  logic                 rst,
  input  logic                 rx_ready,
  input  logic [7:0]           rx_data,
  input  logic [NUM_CH-1:0]    mtr_active,
  output logic [15*NUM_CH-1:0] divider_o,
  output logic [13*NUM_CH-1:0] steps_o,
  output logic [NUM_CH-1:0]    cmd_load,
  output logic [NUM_CH-1:0]    pending,
  output logic                 err_overrun,
  output logic                 err_badch,
  output logic                 err_timeout
);

  localparam int            TW         = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_PAYLOAD = 2'd1;
  localparam logic [1:0] c_COMMIT  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [3:0]           ch_q, ch_d;
  logic [31:0]          sh_q, sh_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 rx_ready_q;
  logic [NUM_CH-1:0]    mtr_active_q;
  logic [15*NUM_CH-1:0] divider_q, divider_d;
  logic [13*NUM_CH-1:0] steps_q, steps_d;
  logic [NUM_CH-1:0]    load_q, load_d;
  logic [NUM_CH-1:0]    pending_q, pending_d;
  logic                 err_ovr_q, err_ovr_d;
  logic                 err_bad_q, err_bad_d;
  logic                 err_tmo_q, err_tmo_d;

  logic                 w_byte_stb;
  logic [NUM_CH-1:0]    w_act_rise;
  logic                 w_unused;

  assign w_byte_stb = rx_ready & ~rx_ready_q;
  assign w_act_rise = mtr_active & ~mtr_active_q;
  assign w_unused   = ^sh_q[3:0];

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    divider_d = divider_q;
    steps_d   = steps_q;
    load_d    = '0;
    err_ovr_d = 1'b0;
    err_bad_d = 1'b0;
    err_tmo_d = 1'b0;

    // Controller start is applied before any commit, so a same-cycle commit sees it free.
    pending_d = pending_q & ~w_act_rise;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_act_rise[c]) begin
        steps_d[13*c +: 13] = '0;
      end
    end

    case (state_q)
      c_IDLE: begin
        if (w_byte_stb) begin
          ch_d    = rx_data[3:0];
          sh_d    = '0;
          cnt_d   = '0;
          timer_d = '0;
          state_d = c_PAYLOAD;
        end
      end

      c_PAYLOAD: begin
        if (w_byte_stb) begin
          sh_d    = {rx_data, sh_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          timer_d = '0;
          if (cnt_q == 2'd3) begin
            state_d = c_COMMIT;
          end
        end else if (timer_q == c_TMO_LAST) begin
          err_tmo_d = 1'b1;
          state_d   = c_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      c_COMMIT: begin
        state_d = c_IDLE;
        if (int'(ch_q) >= NUM_CH) begin
          err_bad_d = 1'b1;
        end else begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == 4'(c)) begin
              if (pending_d[c]) begin
                err_ovr_d = 1'b1;
              end else begin
                divider_d[15*c +: 15] = sh_q[18:4];
                steps_d[13*c +: 13]   = sh_q[31:19];
                pending_d[c]          = 1'b1;
                load_d[c]             = 1'b1;
              end
            end
          end
        end
      end

      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge CLK_SE_AR) begin
    if (rst) begin
      state_q      <= c_IDLE;
      ch_q         <= '0;
      sh_q         <= '0;
      cnt_q        <= '0;
      timer_q      <= '0;
      rx_ready_q   <= 1'b0;
      mtr_active_q <= '0;
      divider_q    <= '0;
      steps_q      <= '0;
      load_q       <= '0;
      pending_q    <= '0;
      err_ovr_q    <= 1'b0;
      err_bad_q    <= 1'b0;
      err_tmo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      rx_ready_q   <= rx_ready;
      mtr_active_q <= mtr_active;
      divider_q    <= divider_d;
      steps_q      <= steps_d;
      load_q       <= load_d;
      pending_q    <= pending_d;
      err_ovr_q    <= err_ovr_d;
      err_bad_q    <= err_bad_d;
      err_tmo_q    <= err_tmo_d;
    end
  end

  assign divider_o   = divider_q;
  assign steps_o     = steps_q;
  assign cmd_load    = load_q;
  assign pending     = pending_q;
  assign err_overrun = err_ovr_q;
  assign err_badch   = err_bad_q;
  assign err_timeout = err_tmo_q;

endmodule
`default_nettype wire
